// File: rtl/l15_resp_pkg.sv
// Shared types and helpers for the L1.5 responder: request/return codes, FSM states,
// byte swap between the big-endian L1.5 side and the little-endian memory, byte enables.
package l15_resp_pkg;

  // L1.5 request types as driven by the core's L1.5 adapter
  typedef enum logic [4:0] {
    RqLoad  = 5'b00000,
    RqStore = 5'b00001,
    RqIfill = 5'b10000
  } rqtype_e;

  // L1.5 return types as decoded by the core's L1.5 adapter
  typedef enum logic [3:0] {
    RetLoad  = 4'b0000,
    RetIfill = 4'b0001,
    RetStAck = 4'b0100
  } rettype_e;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StWr,
    StResp
  } state_e;

  // Little-endian byte k lands in big-endian byte lane k (bits [63-8k -: 8])
  function automatic logic [63:0] byteswap64(input logic [63:0] d);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      r[63-8*k -: 8] = d[8*k +: 8];
    end
    return r;
  endfunction

  // Byte-enable mask for an access of 1<<size bytes at byte offset off in a 64-bit word
  function automatic logic [7:0] be_from_size(input logic [2:0] size, input logic [2:0] off);
    logic [7:0] m;
    case (size)
      3'd0:    m = 8'h01;
      3'd1:    m = 8'h03;
      3'd2:    m = 8'h0F;
      3'd3:    m = 8'hFF;
      default: m = 8'h00;
    endcase
    return m << off;
  endfunction

endpackage

// File: rtl/l15_resp_line_asm.sv
// Read-line assembly: counts returned memory words, byte-swaps each into its slot of the
// return line, and flags the last expected word.
module l15_resp_line_asm #(
  parameter int unsigned LineWidth = 128,
  parameter int unsigned CntWidth  = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 rvalid_i,
  input  logic [63:0]          rdata_i,
  input  logic [CntWidth-1:0]  beats_i,
  output logic                 last_o,
  output logic [LineWidth-1:0] line_o
);
  import l15_resp_pkg::*;

  localparam int unsigned Words = LineWidth / 64;

  logic [CntWidth-1:0]  rcv_q, rcv_d;
  logic [LineWidth-1:0] line_q, line_d;

  assign last_o = rvalid_i && ((rcv_q + CntWidth'(1)) == beats_i);
  assign line_o = line_q;

  // Clear on a new request so nc-load upper words and store acks read back as zero
  always_comb begin
    rcv_d  = rcv_q;
    line_d = line_q;
    if (clear_i) begin
      rcv_d  = '0;
      line_d = '0;
    end else if (rvalid_i) begin
      for (int w = 0; w < Words; w++) begin
        if (rcv_q == CntWidth'(w)) begin
          line_d[64*w +: 64] = byteswap64(rdata_i);
        end
      end
      rcv_d = rcv_q + CntWidth'(1);
    end
  end

  // Receive counter and line register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rcv_q  <= '0;
      line_q <= '0;
    end else begin
      rcv_q  <= rcv_d;
      line_q <= line_d;
    end
  end

endmodule

// File: rtl/l15_resp_engine.sv
// L1.5 request responder: serves one load / ifill / store at a time from a simple SRAM-style
// memory port and returns the matching big-endian L1.5 return packet.
module l15_resp_engine #(
  parameter int unsigned LineWidth = 128,
  parameter int unsigned AddrWidth = 40,
  parameter int unsigned TidWidth  = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_val_i,
  input  logic [4:0]           req_rqtype_i,
  input  logic                 req_nc_i,
  input  logic [2:0]           req_size_i,
  input  logic [TidWidth-1:0]  req_threadid_i,
  input  logic [AddrWidth-1:0] req_address_i,
  input  logic [63:0]          req_data_i,
  output logic                 req_header_ack_o,
  output logic                 rtrn_val_o,
  input  logic                 rtrn_ack_i,
  output logic [3:0]           rtrn_returntype_o,
  output logic                 rtrn_nc_o,
  output logic [TidWidth-1:0]  rtrn_threadid_o,
  output logic [LineWidth-1:0] rtrn_data_o,
  output logic                 mem_req_o,
  input  logic                 mem_gnt_i,
  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [7:0]           mem_be_o,
  output logic [63:0]          mem_wdata_o,
  input  logic                 mem_rvalid_i,
  input  logic [63:0]          mem_rdata_i,
  output logic                 err_o
);
  import l15_resp_pkg::*;

  localparam int unsigned MaxBeats = LineWidth / 64;
  localparam int unsigned CntWidth = $clog2(MaxBeats) + 1;
  localparam logic [AddrWidth-1:0] LineMask = ~AddrWidth'(LineWidth / 8 - 1);
  localparam logic [AddrWidth-1:0] WordMask = ~AddrWidth'(7);

  state_e               state_q, state_d;
  logic [4:0]           rqtype_q, rqtype_d;
  logic                 nc_q, nc_d;
  logic [2:0]           size_q, size_d;
  logic [TidWidth-1:0]  tid_q, tid_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [63:0]          data_q, data_d;
  logic [CntWidth-1:0]  beats_q, beats_d;
  logic [CntWidth-1:0]  issued_q, issued_d;
  logic                 err_q, err_d;

  logic accept;
  logic misaligned;
  logic rd_last;

  assign accept           = (state_q == StIdle) && req_val_i;
  assign req_header_ack_o = accept;
  assign rtrn_val_o       = (state_q == StResp);
  assign rtrn_nc_o        = nc_q;
  assign rtrn_threadid_o  = tid_q;
  assign err_o            = err_q;

  l15_resp_line_asm #(
    .LineWidth (LineWidth),
    .CntWidth  (CntWidth)
  ) u_line_asm (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (accept),
    .rvalid_i (mem_rvalid_i && (state_q == StRd)),
    .rdata_i  (mem_rdata_i),
    .beats_i  (beats_q),
    .last_o   (rd_last),
    .line_o   (rtrn_data_o)
  );

  // Store alignment: offset must be a multiple of the access size; sizes above 8B are illegal
  always_comb begin
    case (size_q)
      3'd0:    misaligned = 1'b0;
      3'd1:    misaligned = addr_q[0];
      3'd2:    misaligned = |addr_q[1:0];
      3'd3:    misaligned = |addr_q[2:0];
      default: misaligned = 1'b1;
    endcase
  end

  // Return type follows the registered request type
  always_comb begin
    case (rqtype_q)
      RqIfill: rtrn_returntype_o = RetIfill;
      RqStore: rtrn_returntype_o = RetStAck;
      default: rtrn_returntype_o = RetLoad;
    endcase
  end

  // FSM next state, request capture and memory port drive
  always_comb begin
    state_d     = state_q;
    rqtype_d    = rqtype_q;
    nc_d        = nc_q;
    size_d      = size_q;
    tid_d       = tid_q;
    addr_d      = addr_q;
    data_d      = data_q;
    beats_d     = beats_q;
    issued_d    = issued_q;
    err_d       = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    unique case (state_q)
      StIdle: begin
        if (req_val_i) begin
          rqtype_d = req_rqtype_i;
          nc_d     = req_nc_i;
          size_d   = req_size_i;
          tid_d    = req_threadid_i;
          data_d   = req_data_i;
          addr_d   = req_address_i;
          issued_d = '0;
          beats_d  = CntWidth'(MaxBeats);
          case (req_rqtype_i)
            RqLoad: begin
              state_d = StRd;
              if (req_nc_i) begin
                beats_d = CntWidth'(1);
                addr_d  = req_address_i & WordMask;
              end else begin
                addr_d  = req_address_i & LineMask;
              end
            end
            // Instruction fills always fetch the whole line
            RqIfill: begin
              state_d = StRd;
              addr_d  = req_address_i & LineMask;
            end
            RqStore: state_d = StWr;
            default: err_d = 1'b1;
          endcase
        end
      end
      StRd: begin
        if (issued_q < beats_q) begin
          mem_req_o  = 1'b1;
          mem_be_o   = 8'hFF;
          mem_addr_o = addr_q + (AddrWidth'(issued_q) << 3);
          if (mem_gnt_i) begin
            issued_d = issued_q + CntWidth'(1);
          end
        end
        if (rd_last) begin
          state_d = StResp;
        end
      end
      StWr: begin
        if (misaligned) begin
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          mem_req_o   = 1'b1;
          mem_we_o    = 1'b1;
          mem_addr_o  = addr_q & WordMask;
          mem_be_o    = be_from_size(size_q, addr_q[2:0]);
          mem_wdata_o = byteswap64(data_q);
          if (mem_gnt_i) begin
            state_d = StResp;
          end
        end
      end
      StResp: begin
        if (rtrn_ack_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and request registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      rqtype_q <= '0;
      nc_q     <= 1'b0;
      size_q   <= '0;
      tid_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      beats_q  <= '0;
      issued_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rqtype_q <= rqtype_d;
      nc_q     <= nc_d;
      size_q   <= size_d;
      tid_q    <= tid_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      beats_q  <= beats_d;
      issued_q <= issued_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_l15_resp_engine.sv
// Scoreboard bench for l15_resp_engine: random requests against a byte-addressed reference
// memory, a stalling memory responder, and a return monitor with random ack hold-off.
module tb_l15_resp_engine;
  import l15_resp_pkg::*;

  localparam int unsigned LW = 128;
  localparam int unsigned AW = 40;
  localparam int unsigned TW = 2;
  localparam logic [AW-1:0] REGION = 40'h00_8000_0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_val_i;
  logic [4:0]    req_rqtype_i;
  logic          req_nc_i;
  logic [2:0]    req_size_i;
  logic [TW-1:0] req_threadid_i;
  logic [AW-1:0] req_address_i;
  logic [63:0]   req_data_i;
  logic          req_header_ack_o;
  logic          rtrn_val_o;
  logic          rtrn_ack_i;
  logic [3:0]    rtrn_returntype_o;
  logic          rtrn_nc_o;
  logic [TW-1:0] rtrn_threadid_o;
  logic [LW-1:0] rtrn_data_o;
  logic          mem_req_o;
  logic          mem_gnt_i;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [7:0]    mem_be_o;
  logic [63:0]   mem_wdata_o;
  logic          mem_rvalid_i;
  logic [63:0]   mem_rdata_i;
  logic          err_o;

  always #5 clk = ~clk;

  l15_resp_engine #(
    .LineWidth (LW),
    .AddrWidth (AW),
    .TidWidth  (TW)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .req_val_i         (req_val_i),
    .req_rqtype_i      (req_rqtype_i),
    .req_nc_i          (req_nc_i),
    .req_size_i        (req_size_i),
    .req_threadid_i    (req_threadid_i),
    .req_address_i     (req_address_i),
    .req_data_i        (req_data_i),
    .req_header_ack_o  (req_header_ack_o),
    .rtrn_val_o        (rtrn_val_o),
    .rtrn_ack_i        (rtrn_ack_i),
    .rtrn_returntype_o (rtrn_returntype_o),
    .rtrn_nc_o         (rtrn_nc_o),
    .rtrn_threadid_o   (rtrn_threadid_o),
    .rtrn_data_o       (rtrn_data_o),
    .mem_req_o         (mem_req_o),
    .mem_gnt_i         (mem_gnt_i),
    .mem_we_o          (mem_we_o),
    .mem_addr_o        (mem_addr_o),
    .mem_be_o          (mem_be_o),
    .mem_wdata_o       (mem_wdata_o),
    .mem_rvalid_i      (mem_rvalid_i),
    .mem_rdata_i       (mem_rdata_i),
    .err_o             (err_o)
  );

  typedef struct packed {
    logic [3:0]    rt;
    logic          nc;
    logic [TW-1:0] tid;
    logic [LW-1:0] data;
  } ret_t;

  ret_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [7:0] bus_mem[logic [AW-1:0]];
  logic [7:0] ref_mem[logic [AW-1:0]];

  int gnt_pct = 100;
  int rv_pct = 100;
  int force_hold = 0;
  int rd_grants = 0, wr_grants = 0, req_cycles = 0, err_seen = 0;
  int exp_reads = 0, exp_writes = 0, exp_err = 0;
  logic [AW-1:0] last_rd_addr, last_wr_addr;
  logic [7:0]    last_be;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got timeout want response", name);
  endtask

  // Unwritten memory holds a fixed address pattern: byte at 0x..10 is 0x00, 0x..18 is 0x08
  function automatic logic [7:0] dflt(input logic [AW-1:0] a);
    return a[7:0] - 8'h10;
  endfunction

  function automatic logic [7:0] bus_rd(input logic [AW-1:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : dflt(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  // Reference model: byte-level effect of a request and the return it should produce
  task automatic model(input logic [4:0] t, input logic nc, input logic [2:0] sz,
                       input logic [TW-1:0] tid, input logic [AW-1:0] a, input logic [63:0] d);
    ret_t e;
    int   n, bytes, lane;
    logic [AW-1:0] base;
    e.nc   = nc;
    e.tid  = tid;
    e.data = '0;
    if (t == RqStore) begin
      e.rt = RetStAck;
      n = 1 << sz;
      if (sz <= 3 && (a % n) == 0) begin
        // Big-endian data byte j belongs to the address whose offset in the 8B word is j
        for (int k = 0; k < n; k++) begin
          lane = int'(a % 8) + k;
          ref_mem[AW'(a + k)] = d[63-8*lane -: 8];
        end
        exp_writes++;
      end else begin
        exp_err++;
      end
      exp_q.push_back(e);
    end else if (t == RqLoad || t == RqIfill) begin
      bytes = (t == RqLoad && nc) ? 8 : LW / 8;
      base  = a - AW'(a % bytes);
      for (int i = 0; i < bytes; i++) begin
        e.data[64*(i/8) + 63 - 8*(i%8) -: 8] = ref_rd(AW'(base + i));
      end
      exp_reads += bytes / 8;
      e.rt = (t == RqIfill) ? RetIfill : RetLoad;
      exp_q.push_back(e);
    end else begin
      exp_err++;
    end
  endtask

  // Present a request and hold it until the header ack; optionally record its expectation
  task automatic send(input logic [4:0] t, input logic nc, input logic [2:0] sz,
                      input logic [TW-1:0] tid, input logic [AW-1:0] a, input logic [63:0] d,
                      input bit track);
    int waited;
    waited         = 0;
    req_rqtype_i   = t;
    req_nc_i       = nc;
    req_size_i     = sz;
    req_threadid_i = tid;
    req_address_i  = a;
    req_data_i     = d;
    req_val_i      = 1'b1;
    #1;
    while (!req_header_ack_o && waited < 3000) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!req_header_ack_o) begin
      fail_now("header_ack");
    end else begin
      if (track) model(t, nc, sz, tid, a, d);
      @(negedge clk);
    end
    req_val_i = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    repeat (3) @(negedge clk);
    while ((exp_q.size() != 0 || rtrn_val_o) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 3000) fail_now("idle");
    repeat (2) @(negedge clk);
  endtask

  task automatic check_outs_zero(input string name);
    check(name, {rtrn_val_o, rtrn_returntype_o, rtrn_nc_o, rtrn_threadid_o, rtrn_data_o,
                 mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o, err_o,
                 req_header_ack_o}, '0);
  endtask

  // Counts negedges from the cycle after acceptance until the return is valid
  task automatic ret_latency(output int lat);
    lat = 1;
    while (!rtrn_val_o && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Memory responder: random grants, in-order read data at least one cycle after the grant
  logic [63:0]  rd_data_q[$];
  int unsigned  rd_time_q[$];
  int unsigned  cyc = 0;
  initial begin
    logic [63:0] w;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      if (!rst_n) begin
        rd_data_q.delete();
        rd_time_q.delete();
      end else begin
        if (rd_data_q.size() > 0 && rd_time_q[0] <= cyc && $urandom_range(99) < rv_pct) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = rd_data_q.pop_front();
          void'(rd_time_q.pop_front());
        end
        if (mem_req_o) begin
          req_cycles++;
          if ($urandom_range(99) < gnt_pct) begin
            mem_gnt_i = 1'b1;
            if (mem_we_o) begin
              wr_grants++;
              last_wr_addr = mem_addr_o;
              last_be      = mem_be_o;
              for (int k = 0; k < 8; k++) begin
                if (mem_be_o[k]) bus_mem[AW'(mem_addr_o + k)] = mem_wdata_o[8*k +: 8];
              end
            end else begin
              rd_grants++;
              last_rd_addr = mem_addr_o;
              for (int k = 0; k < 8; k++) w[8*k +: 8] = bus_rd(AW'(mem_addr_o + k));
              rd_data_q.push_back(w);
              rd_time_q.push_back(cyc + 1);
            end
          end
        end
      end
    end
  end

  // Return monitor: compare against the scoreboard, check stability while ack is withheld
  initial begin
    ret_t act, snap;
    bit   busy;
    int   hold, waited;
    busy       = 1'b0;
    hold       = 0;
    waited     = 0;
    snap       = '0;
    rtrn_ack_i = 1'b0;
    forever begin
      @(negedge clk);
      act        = {rtrn_returntype_o, rtrn_nc_o, rtrn_threadid_o, rtrn_data_o};
      rtrn_ack_i = 1'b0;
      if (!rst_n) begin
        busy = 1'b0;
      end else if (rtrn_val_o) begin
        if (!busy) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_return: got %0h want none", act);
          end else begin
            check("return", act, exp_q.pop_front());
          end
          busy   = 1'b1;
          snap   = act;
          waited = 0;
          hold   = (force_hold >= 0) ? force_hold : int'($urandom_range(5));
        end else begin
          check("return_stable", act, snap);
        end
        if (waited >= hold) begin
          rtrn_ack_i = 1'b1;
          busy       = 1'b0;
        end else begin
          waited++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && err_o) err_seen++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, r0, w0, e0, q0;
    logic [4:0]    t;
    logic [2:0]    sz;
    logic [AW-1:0] a;
    logic [63:0]   d;
    int            r;
    req_val_i      = 1'b0;
    req_rqtype_i   = '0;
    req_nc_i       = 1'b0;
    req_size_i     = '0;
    req_threadid_i = '0;
    req_address_i  = '0;
    req_data_i     = '0;
    rst_n          = 1'b0;
    repeat (3) @(negedge clk);
    check_outs_zero("reset_outputs");
    rst_n = 1'b1;
    @(negedge clk);

    // Cacheable line load
    r0 = rd_grants;
    send(RqLoad, 1'b0, 3'd3, 2'd2, REGION + AW'(24), '0, 1'b1);
    ret_latency(lat);
    check("load_latency", lat, 4);
    check("load_line", rtrn_data_o, {64'h08090A0B0C0D0E0F, 64'h0001020304050607});
    wait_idle();
    check("load_reads", rd_grants - r0, 2);

    // Non-cacheable 8B load: a single word read
    r0 = rd_grants;
    send(RqLoad, 1'b1, 3'd3, 2'd1, REGION + AW'(24), '0, 1'b1);
    wait_idle();
    check("nc_reads", rd_grants - r0, 1);
    check("nc_addr", last_rd_addr, REGION + AW'(24));

    // 2B store at offset 6, data replicated across the big-endian word
    w0 = wr_grants;
    send(RqStore, 1'b0, 3'd1, 2'd3, REGION + AW'(6), 64'hAABB_AABB_AABB_AABB, 1'b1);
    ret_latency(lat);
    check("store_latency", lat, 2);
    wait_idle();
    check("store_writes", wr_grants - w0, 1);
    check("store_be", last_be, 8'hC0);
    check("store_bytes", {bus_rd(REGION + AW'(6)), bus_rd(REGION + AW'(7))}, 16'hAABB);

    // Misaligned 4B store: no memory access, one error pulse, still acked
    q0 = req_cycles;
    e0 = err_seen;
    send(RqStore, 1'b0, 3'd2, 2'd0, REGION + AW'(2), 64'h1234_5678_9ABC_DEF0, 1'b1);
    wait_idle();
    check("misaligned_noreq", req_cycles - q0, 0);
    check("misaligned_err", err_seen - e0, 1);

    // Unsupported request type: acked, one error pulse, no return, back in IDLE
    e0 = err_seen;
    send(5'b00110, 1'b0, 3'd3, 2'd1, REGION, '0, 1'b1);
    req_rqtype_i = RqIfill;
    req_nc_i     = 1'b1;
    req_val_i    = 1'b1;
    #1;
    check("bad_type_idle", req_header_ack_o, 1'b1);
    send(RqIfill, 1'b1, 3'd3, 2'd1, REGION + AW'(40), '0, 1'b1);
    wait_idle();
    check("bad_type_err", err_seen - e0, 1);

    // Stalled memory with the return held for 5 cycles
    gnt_pct    = 40;
    rv_pct     = 40;
    force_hold = 5;
    send(RqIfill, 1'b0, 3'd3, 2'd2, REGION + AW'(16), '0, 1'b1);
    send(RqStore, 1'b1, 3'd3, 2'd1, REGION + AW'(16), 64'h0102_0304_0506_0708, 1'b1);
    send(RqLoad, 1'b0, 3'd0, 2'd0, REGION + AW'(31), '0, 1'b1);
    wait_idle();

    // Random traffic over a small region so stores and loads overlap
    force_hold = -1;
    gnt_pct    = 60;
    rv_pct     = 60;
    for (int i = 0; i < 150; i++) begin
      r = int'($urandom_range(99));
      if (r < 35)      t = RqLoad;
      else if (r < 55) t = RqIfill;
      else if (r < 92) t = RqStore;
      else if (r < 96) t = 5'b00110;
      else             t = 5'b11111;
      sz = 3'($urandom_range(3));
      if ($urandom_range(9) == 0) sz = 3'($urandom_range(7));
      a = REGION + AW'($urandom_range(63));
      if (t == RqStore && sz <= 3'd3 && $urandom_range(9) != 0) begin
        a = a & ~AW'((1 << sz) - 1);
      end
      d = {$urandom, $urandom};
      send(t, 1'($urandom_range(1)), sz, TW'($urandom_range(3)), a, d, 1'b1);
      if ($urandom_range(3) == 0) repeat ($urandom_range(3)) @(negedge clk);
    end
    wait_idle();
    check("total_reads", rd_grants, exp_reads);
    check("total_writes", wr_grants, exp_writes);
    check("total_errors", err_seen, exp_err);

    // Reset in the middle of a line read, then a clean request
    gnt_pct = 30;
    send(RqLoad, 1'b0, 3'd3, 2'd1, REGION, '0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_outs_zero("midrd_reset_outputs");
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    gnt_pct = 100;
    rv_pct  = 100;
    @(negedge clk);
    r0 = rd_grants;
    send(RqLoad, 1'b0, 3'd3, 2'd3, REGION + AW'(8), '0, 1'b1);
    wait_idle();
    check("after_reset_reads", rd_grants - r0, 2);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
